// File: rtl/bulk_endp_pkg.sv
// Shared definitions for the bulk endpoint pair: FSM state encodings and a
// constant ceil(log2) helper used to size pointers, levels and counters.
package bulk_endp_pkg;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_DATA = 2'd1,
    OUT_NAK  = 2'd2
  } out_state_t;

  typedef enum logic [1:0] {
    IN_IDLE     = 2'd0,
    IN_SEND     = 2'd1,
    IN_WAIT_ACK = 2'd2
  } in_state_t;

  // Smallest r with 2**r >= value.
  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_spec.sv
// Byte FIFO with committed and speculative pointers on both sides.
// The writer side may be speculative (OUT: packet bytes land ahead of the
// committed write pointer until commit/revert); the reader side may be
// speculative (IN: packet bytes are read ahead of the committed read pointer
// until the host ACKs, so a retry can reload and resend them).
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   wr_en, wr_data          write a byte at the speculative write pointer
//   wr_commit, wr_revert    speculative write pointer -> committed / back
//   rd_adv                  advance the speculative read pointer
//   rd_load, rd_commit      reload spec read from committed / commit it
//   rd_data                 byte at the speculative read pointer
//   avail                   spec read pointer != committed write pointer
//   full                    no room for the writer
//   level                   committed write minus committed read
module sync_fifo_spec
  import bulk_endp_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter bit          SPEC_WR = 1'b1,
  parameter bit          SPEC_RD = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_commit,
  input  logic                       wr_revert,
  input  logic                       rd_adv,
  input  logic                       rd_load,
  input  logic                       rd_commit,
  output logic [7:0]                 rd_data,
  output logic                       avail,
  output logic                       full,
  output logic [ceil_log2(DEPTH):0]  level
);

  localparam int unsigned W  = ceil_log2(DEPTH);
  localparam int unsigned PW = W + 1;

  logic [PW-1:0] wr_ptr, wr_spec, rd_ptr, rd_spec;
  logic [PW-1:0] wr_ptr_nxt, wr_spec_nxt, rd_ptr_nxt, rd_spec_nxt;
  logic [7:0]    mem [DEPTH];

  // Pointer next-state; a non-speculative side keeps committed == speculative.
  always_comb begin
    wr_spec_nxt = wr_spec;
    if (wr_revert)   wr_spec_nxt = wr_ptr;
    else if (wr_en)  wr_spec_nxt = wr_spec + PW'(1);

    wr_ptr_nxt = wr_ptr;
    if (!SPEC_WR)       wr_ptr_nxt = wr_spec_nxt;
    else if (wr_commit) wr_ptr_nxt = wr_spec;

    rd_spec_nxt = rd_spec;
    if (rd_load)     rd_spec_nxt = rd_ptr;
    else if (rd_adv) rd_spec_nxt = rd_spec + PW'(1);

    rd_ptr_nxt = rd_ptr;
    if (!SPEC_RD)       rd_ptr_nxt = rd_spec_nxt;
    else if (rd_commit) rd_ptr_nxt = rd_spec;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      wr_spec <= '0;
      rd_ptr  <= '0;
      rd_spec <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      wr_spec <= wr_spec_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_spec <= rd_spec_nxt;
    end
  end

  // Storage, not reset: pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en && !wr_revert) mem[wr_spec[W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_spec[W-1:0]];
  assign avail   = (rd_spec != wr_ptr);
  // Unacked IN bytes and uncommitted OUT bytes both still occupy space.
  assign full    = (wr_spec[W] != rd_ptr[W]) && (wr_spec[W-1:0] == rd_ptr[W-1:0]);
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/bulk_endp_fifo.sv
// USB full-speed bulk IN/OUT endpoint pair between the SIE and the app.
// OUT packets are staged speculatively and committed on a clean end of
// packet; a packet is NAKed at its first byte if a full-size packet would
// not fit. IN packets are read speculatively and only retired on ACK, so an
// unacknowledged packet is resent; an optional ZLP follows a full-size packet
// that drains the FIFO.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   app_in_data_i/valid_i/ready_o      app byte stream into the IN FIFO
//   app_out_data_o/valid_o/ready_i     committed OUT bytes to the app
//   in_level_o, out_level_o            committed byte counts
//   in_req_i, in_ready_i               SIE IN transaction / byte consumed
//   in_data_o, in_valid_o, in_nak_o    IN byte, byte valid, NAK token
//   out_data_i/valid_i/err_i/ready_i   SIE OUT byte, error and strobe
//   out_nak_o                          current OUT packet is NAKed
module bulk_endp_fifo
  import bulk_endp_pkg::*;
#(
  parameter int unsigned IN_MAXPACKETSIZE  = 8,
  parameter int unsigned OUT_MAXPACKETSIZE = 8,
  parameter int unsigned IN_DEPTH          = 16,
  parameter int unsigned OUT_DEPTH         = 16,
  parameter bit          ZLP_EN            = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    app_in_data_i,
  input  logic                          app_in_valid_i,
  output logic                          app_in_ready_o,
  output logic [7:0]                    app_out_data_o,
  output logic                          app_out_valid_o,
  input  logic                          app_out_ready_i,
  output logic [ceil_log2(IN_DEPTH):0]  in_level_o,
  output logic [ceil_log2(OUT_DEPTH):0] out_level_o,
  input  logic                          in_req_i,
  input  logic                          in_ready_i,
  output logic [7:0]                    in_data_o,
  output logic                          in_valid_o,
  output logic                          in_nak_o,
  input  logic [7:0]                    out_data_i,
  input  logic                          out_valid_i,
  input  logic                          out_err_i,
  input  logic                          out_ready_i,
  output logic                          out_nak_o
);

  localparam int unsigned IW  = ceil_log2(IN_DEPTH);
  localparam int unsigned OW  = ceil_log2(OUT_DEPTH);
  localparam int unsigned ICW = ceil_log2(IN_MAXPACKETSIZE + 1);
  localparam int unsigned OCW = ceil_log2(OUT_MAXPACKETSIZE + 1);

  // ---------------------------------------------------------------- OUT side
  out_state_t     out_state;
  logic [OCW-1:0] out_cnt;
  logic           out_wr_en, out_commit, out_revert;
  logic           out_avail, out_full, out_no_room, out_eop;
  logic [OW:0]    out_level, out_free;

  assign out_eop     = out_ready_i && !out_valid_i && !out_err_i;
  assign out_free    = (OW+1)'(OUT_DEPTH) - out_level;
  assign out_no_room = out_free < (OW+1)'(OUT_MAXPACKETSIZE);

  // FIFO strobes for the current OUT strobe.
  always_comb begin
    out_wr_en  = 1'b0;
    out_commit = 1'b0;
    out_revert = 1'b0;
    if (out_ready_i) begin
      if (out_err_i) begin
        out_revert = 1'b1;
      end else if (out_valid_i) begin
        case (out_state)
          OUT_IDLE: out_wr_en = !out_no_room && !out_full;
          OUT_DATA: out_wr_en = (out_cnt < OCW'(OUT_MAXPACKETSIZE)) && !out_full;
          default:  out_wr_en = 1'b0;
        endcase
      end else begin
        out_commit = (out_state == OUT_DATA);
        out_revert = (out_state == OUT_NAK);
      end
    end
  end

  // OUT packet FSM; advances only on the SIE strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_state <= OUT_IDLE;
      out_cnt   <= '0;
      out_nak_o <= 1'b0;
    end else if (out_ready_i) begin
      if (out_err_i || !out_valid_i) begin
        out_state <= OUT_IDLE;
        out_cnt   <= '0;
        out_nak_o <= 1'b0;
      end else begin
        case (out_state)
          OUT_IDLE: begin
            if (out_no_room) begin
              out_state <= OUT_NAK;
              out_nak_o <= 1'b1;
            end else begin
              out_state <= OUT_DATA;
              out_cnt   <= OCW'(1);
            end
          end
          OUT_DATA: begin
            // An overlong packet is dropped as a whole.
            if (out_cnt < OCW'(OUT_MAXPACKETSIZE)) begin
              out_cnt <= out_cnt + OCW'(1);
            end else begin
              out_state <= OUT_NAK;
              out_nak_o <= 1'b1;
            end
          end
          default: out_state <= OUT_NAK;
        endcase
      end
    end
  end

  sync_fifo_spec #(
    .DEPTH   (OUT_DEPTH),
    .SPEC_WR (1'b1),
    .SPEC_RD (1'b0)
  ) u_out_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en     (out_wr_en),
    .wr_data   (out_data_i),
    .wr_commit (out_commit),
    .wr_revert (out_revert),
    .rd_adv    (app_out_ready_i && out_avail),
    .rd_load   (1'b0),
    .rd_commit (1'b0),
    .rd_data   (app_out_data_o),
    .avail     (out_avail),
    .full      (out_full),
    .level     (out_level)
  );

  assign app_out_valid_o = out_avail;
  assign out_level_o     = out_level;

  // ----------------------------------------------------------------- IN side
  in_state_t      in_state;
  logic [ICW-1:0] in_sent;
  logic           in_req_q, in_rise, in_fall;
  logic           in_adv, in_load, in_ack;
  logic           in_avail, in_full, zlp_pending;
  logic [7:0]     in_rd_data;
  logic [IW:0]    in_level;

  assign in_rise = in_req_i && !in_req_q;
  assign in_fall = !in_req_i && in_req_q;

  assign in_valid_o = (in_state == IN_SEND) && in_avail &&
                      (in_sent < ICW'(IN_MAXPACKETSIZE));
  assign in_data_o  = in_valid_o ? in_rd_data : 8'h00;
  assign in_adv     = in_valid_o && in_ready_i;
  assign in_load    = in_rise && (in_state != IN_SEND);
  // A retry (new token) takes precedence over a handshake strobe.
  assign in_ack     = (in_state == IN_WAIT_ACK) && !in_rise && out_eop;

  // IN transaction FSM with NAK and ZLP tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_state    <= IN_IDLE;
      in_req_q    <= 1'b0;
      in_sent     <= '0;
      in_nak_o    <= 1'b1;
      zlp_pending <= 1'b0;
    end else begin
      in_req_q <= in_req_i;
      case (in_state)
        IN_IDLE: begin
          in_nak_o <= (in_level == '0) && !zlp_pending;
          if (in_rise) begin
            in_state <= IN_SEND;
            in_sent  <= '0;
          end
        end
        IN_SEND: begin
          if (in_adv) in_sent <= in_sent + ICW'(1);
          if (in_fall) in_state <= IN_WAIT_ACK;
        end
        IN_WAIT_ACK: begin
          if (in_rise) begin
            in_state <= IN_SEND;
            in_sent  <= '0;
          end else if (in_ack) begin
            in_state    <= IN_IDLE;
            // After commit the FIFO is empty when spec read meets write.
            zlp_pending <= ZLP_EN && (in_sent == ICW'(IN_MAXPACKETSIZE)) && !in_avail;
          end
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  sync_fifo_spec #(
    .DEPTH   (IN_DEPTH),
    .SPEC_WR (1'b0),
    .SPEC_RD (1'b1)
  ) u_in_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en     (app_in_valid_i && !in_full),
    .wr_data   (app_in_data_i),
    .wr_commit (1'b0),
    .wr_revert (1'b0),
    .rd_adv    (in_adv),
    .rd_load   (in_load),
    .rd_commit (in_ack),
    .rd_data   (in_rd_data),
    .avail     (in_avail),
    .full      (in_full),
    .level     (in_level)
  );

  assign app_in_ready_o = !in_full;
  assign in_level_o     = in_level;

endmodule

// File: tb/tb_bulk_endp_fifo.sv
// Randomized self-checking bench for bulk_endp_fifo against a queue model.
module tb_bulk_endp_fifo;

  localparam int MPS_IN    = 8;
  localparam int MPS_OUT   = 8;
  localparam int DEPTH_IN  = 16;
  localparam int DEPTH_OUT = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] app_in_data_i;
  logic       app_in_valid_i;
  logic       app_in_ready_o;
  logic [7:0] app_out_data_o;
  logic       app_out_valid_o;
  logic       app_out_ready_i;
  logic [4:0] in_level_o;
  logic [4:0] out_level_o;
  logic       in_req_i;
  logic       in_ready_i;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_nak_o;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_err_i;
  logic       out_ready_i;
  logic       out_nak_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] in_model[$];
  logic [7:0] out_model[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] pkt_q[$];
  bit         zlp_model;
  logic       nak_first;

  always #5 clk = ~clk;

  bulk_endp_fifo #(
    .IN_MAXPACKETSIZE  (MPS_IN),
    .OUT_MAXPACKETSIZE (MPS_OUT),
    .IN_DEPTH          (DEPTH_IN),
    .OUT_DEPTH         (DEPTH_OUT),
    .ZLP_EN            (1'b1)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .app_in_data_i   (app_in_data_i),
    .app_in_valid_i  (app_in_valid_i),
    .app_in_ready_o  (app_in_ready_o),
    .app_out_data_o  (app_out_data_o),
    .app_out_valid_o (app_out_valid_o),
    .app_out_ready_i (app_out_ready_i),
    .in_level_o      (in_level_o),
    .out_level_o     (out_level_o),
    .in_req_i        (in_req_i),
    .in_ready_i      (in_ready_i),
    .in_data_o       (in_data_o),
    .in_valid_o      (in_valid_o),
    .in_nak_o        (in_nak_o),
    .out_data_i      (out_data_i),
    .out_valid_i     (out_valid_i),
    .out_err_i       (out_err_i),
    .out_ready_i     (out_ready_i),
    .out_nak_o       (out_nak_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    app_in_data_i   = 8'h00;
    app_in_valid_i  = 1'b0;
    app_out_ready_i = 1'b0;
    in_req_i        = 1'b0;
    in_ready_i      = 1'b0;
    out_data_i      = 8'h00;
    out_valid_i     = 1'b0;
    out_err_i       = 1'b0;
    out_ready_i     = 1'b0;
  endtask

  task automatic app_write(input logic [7:0] b);
    app_in_data_i  = b;
    app_in_valid_i = 1'b1;
    tick();
    app_in_valid_i = 1'b0;
    in_model.push_back(b);
  endtask

  // One IN transaction; exp_q gets the model's packet, rx_q what the DUT sent.
  task automatic in_txn(input bit ack, input bit wr_at_ack, input logic [7:0] wb);
    int n;
    int exp_n;
    exp_n = (in_model.size() < MPS_IN) ? in_model.size() : MPS_IN;
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) exp_q.push_back(in_model[i]);
    rx_q.delete();
    in_req_i = 1'b1;
    tick();
    n = 0;
    while (in_valid_o === 1'b1 && n < MPS_IN + 2) begin
      rx_q.push_back(in_data_o);
      in_ready_i = 1'b1;
      tick();
      n++;
    end
    in_ready_i = 1'b0;
    if (n >= MPS_IN + 2) begin
      checks++;
      errors++;
      $display("FAIL in_txn_bound sent=%0d limit=%0d", n, MPS_IN + 1);
    end
    in_req_i = 1'b0;
    tick();
    if (ack) begin
      out_ready_i = 1'b1;
      if (wr_at_ack) begin
        app_in_data_i  = wb;
        app_in_valid_i = 1'b1;
      end
      tick();
      out_ready_i    = 1'b0;
      app_in_valid_i = 1'b0;
      for (int i = 0; i < exp_n; i++) void'(in_model.pop_front());
      zlp_model = (exp_n == MPS_IN) && (in_model.size() == 0);
      if (wr_at_ack) in_model.push_back(wb);
    end
    tick();
    tick();
  endtask

  // Drives pkt_q as one OUT packet, then an end or error strobe.
  task automatic out_pkt(input bit err);
    bit room;
    room = (DEPTH_OUT - out_model.size()) >= MPS_OUT;
    nak_first = 1'bx;
    for (int i = 0; i < pkt_q.size(); i++) begin
      out_data_i  = pkt_q[i];
      out_valid_i = 1'b1;
      out_ready_i = 1'b1;
      tick();
      if (i == 0) nak_first = out_nak_o;
    end
    out_valid_i = 1'b0;
    out_err_i   = err;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    out_err_i   = 1'b0;
    if (room && !err && pkt_q.size() <= MPS_OUT)
      foreach (pkt_q[i]) out_model.push_back(pkt_q[i]);
    tick();
  endtask

  task automatic app_read_all();
    int n;
    rx_q.delete();
    n = 0;
    while (app_out_valid_o === 1'b1 && n < DEPTH_OUT + 2) begin
      rx_q.push_back(app_out_data_o);
      app_out_ready_i = 1'b1;
      tick();
      n++;
    end
    app_out_ready_i = 1'b0;
    if (n >= DEPTH_OUT + 2) begin
      checks++;
      errors++;
      $display("FAIL app_read_bound read=%0d limit=%0d", n, DEPTH_OUT + 1);
    end
    exp_q = out_model;
    out_model.delete();
  endtask

  task automatic test_reset();
    checks++; if (app_in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_app_in_ready got=%b exp=1", app_in_ready_o); end
    checks++; if (app_out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_app_out_valid got=%b exp=0", app_out_valid_o); end
    checks++; if (in_valid_o !== 1'b0) begin errors++; $display("FAIL rst_in_valid got=%b exp=0", in_valid_o); end
    checks++; if (in_nak_o !== 1'b1) begin errors++; $display("FAIL rst_in_nak got=%b exp=1", in_nak_o); end
    checks++; if (out_nak_o !== 1'b0) begin errors++; $display("FAIL rst_out_nak got=%b exp=0", out_nak_o); end
    checks++; if (in_data_o !== 8'h00) begin errors++; $display("FAIL rst_in_data got=%h exp=00", in_data_o); end
    checks++; if (in_level_o !== 5'd0) begin errors++; $display("FAIL rst_in_level got=%0d exp=0", in_level_o); end
    checks++; if (out_level_o !== 5'd0) begin errors++; $display("FAIL rst_out_level got=%0d exp=0", out_level_o); end
  endtask

  task automatic test_in_split();
    for (int i = 0; i < 10; i++) app_write(8'($urandom_range(0, 255)));
    tick();
    checks++; if (in_level_o !== 5'd10) begin errors++; $display("FAIL split_level got=%0d exp=10", in_level_o); end
    checks++; if (in_nak_o !== 1'b0) begin errors++; $display("FAIL split_nak got=%b exp=0", in_nak_o); end
    for (int p = 0; p < 2; p++) begin
      in_txn(1'b1, 1'b0, 8'h00);
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL split_len pkt=%0d got=%0d exp=%0d", p, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL split_byte pkt=%0d idx=%0d got=%h exp=%h", p, i, rx_q[i], exp_q[i]); end
      end
    end
    checks++; if (in_nak_o !== 1'b1) begin errors++; $display("FAIL split_end_nak got=%b exp=1", in_nak_o); end
    checks++; if (in_level_o !== 5'd0) begin errors++; $display("FAIL split_end_level got=%0d exp=0", in_level_o); end
  endtask

  task automatic test_zlp();
    for (int i = 0; i < MPS_IN; i++) app_write(8'($urandom_range(0, 255)));
    in_txn(1'b1, 1'b0, 8'h00);
    checks++; if (rx_q.size() != MPS_IN) begin errors++; $display("FAIL zlp_full_len got=%0d exp=%0d", rx_q.size(), MPS_IN); end
    checks++; if (in_nak_o !== 1'b0) begin errors++; $display("FAIL zlp_pending_nak got=%b exp=0", in_nak_o); end
    in_txn(1'b1, 1'b0, 8'h00);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL zlp_len got=%0d exp=0", rx_q.size()); end
    checks++; if (in_nak_o !== 1'b1) begin errors++; $display("FAIL zlp_done_nak got=%b exp=1", in_nak_o); end
  endtask

  task automatic test_retry();
    for (int i = 0; i < 8; i++) app_write(8'(8'h11 + i));
    in_txn(1'b0, 1'b0, 8'h00);
    checks++; if (in_level_o !== 5'd8) begin errors++; $display("FAIL retry_level got=%0d exp=8", in_level_o); end
    in_txn(1'b1, 1'b0, 8'h00);
    checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL retry_len got=%0d exp=8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      checks++; if (rx_q[i] !== 8'(8'h11 + i)) begin errors++; $display("FAIL retry_byte idx=%0d got=%h exp=%h", i, rx_q[i], 8'(8'h11 + i)); end
    end
    checks++; if (in_level_o !== 5'd0) begin errors++; $display("FAIL retry_acked_level got=%0d exp=0", in_level_o); end
    in_txn(1'b1, 1'b0, 8'h00);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL retry_zlp_len got=%0d exp=0", rx_q.size()); end
  endtask

  task automatic test_out_nak();
    for (int p = 0; p < 2; p++) begin
      pkt_q.delete();
      for (int i = 0; i < (p == 0 ? 8 : 4); i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      out_pkt(1'b0);
    end
    checks++; if (out_level_o !== 5'd12) begin errors++; $display("FAIL onak_fill_level got=%0d exp=12", out_level_o); end
    pkt_q.delete();
    for (int i = 0; i < 5; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    out_pkt(1'b0);
    checks++; if (nak_first !== 1'b1) begin errors++; $display("FAIL onak_first got=%b exp=1", nak_first); end
    checks++; if (out_level_o !== 5'd12) begin errors++; $display("FAIL onak_level got=%0d exp=12", out_level_o); end
    checks++; if (out_nak_o !== 1'b0) begin errors++; $display("FAIL onak_cleared got=%b exp=0", out_nak_o); end
    app_read_all();
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL onak_read_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL onak_read idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_out_err();
    pkt_q.delete();
    for (int i = 0; i < 5; i++) pkt_q.push_back(8'(8'hA0 + i));
    out_pkt(1'b1);
    checks++; if (out_level_o !== 5'd0) begin errors++; $display("FAIL oerr_level got=%0d exp=0", out_level_o); end
    checks++; if (app_out_valid_o !== 1'b0) begin errors++; $display("FAIL oerr_valid got=%b exp=0", app_out_valid_o); end
    pkt_q.delete();
    for (int i = 0; i < 3; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    out_pkt(1'b0);
    checks++; if (out_level_o !== 5'd3) begin errors++; $display("FAIL oerr_good_level got=%0d exp=3", out_level_o); end
    app_read_all();
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL oerr_read_len got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL oerr_read idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int op;
    int n;
    bit ack;
    bit wr;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          n = $urandom_range(0, DEPTH_IN - in_model.size());
          for (int i = 0; i < n; i++) app_write(8'($urandom_range(0, 255)));
          tick();
          checks++; if (in_level_o !== 5'(in_model.size())) begin errors++; $display("FAIL rnd_in_level it=%0d got=%0d exp=%0d", it, in_level_o, in_model.size()); end
          checks++; if (app_in_ready_o !== (in_model.size() < DEPTH_IN)) begin errors++; $display("FAIL rnd_in_ready it=%0d got=%b exp=%b", it, app_in_ready_o, in_model.size() < DEPTH_IN); end
        end
        1: begin
          tick();
          checks++; if (in_nak_o !== (in_model.size() == 0 && !zlp_model)) begin errors++; $display("FAIL rnd_in_nak it=%0d got=%b exp=%b", it, in_nak_o, in_model.size() == 0 && !zlp_model); end
          ack = ($urandom_range(0, 3) != 0);
          wr  = ack && (in_model.size() < MPS_IN) && ($urandom_range(0, 1) == 1);
          in_txn(ack, wr, 8'($urandom_range(0, 255)));
          if (!ack) in_txn(1'b1, 1'b0, 8'h00);
          checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_in_len it=%0d got=%0d exp=%0d", it, rx_q.size(), exp_q.size()); end
          for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_in_byte it=%0d idx=%0d got=%h exp=%h", it, i, rx_q[i], exp_q[i]); end
          end
          checks++; if (in_level_o !== 5'(in_model.size())) begin errors++; $display("FAIL rnd_in_level2 it=%0d got=%0d exp=%0d", it, in_level_o, in_model.size()); end
        end
        2: begin
          bit room;
          room = (DEPTH_OUT - out_model.size()) >= MPS_OUT;
          pkt_q.delete();
          n = $urandom_range(1, MPS_OUT + 2);
          for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
          out_pkt($urandom_range(0, 4) == 0);
          checks++; if (nak_first !== !room) begin errors++; $display("FAIL rnd_out_nak it=%0d got=%b exp=%b", it, nak_first, !room); end
          checks++; if (out_level_o !== 5'(out_model.size())) begin errors++; $display("FAIL rnd_out_level it=%0d got=%0d exp=%0d", it, out_level_o, out_model.size()); end
        end
        default: begin
          app_read_all();
          checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_rd_len it=%0d got=%0d exp=%0d", it, rx_q.size(), exp_q.size()); end
          for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_rd_byte it=%0d idx=%0d got=%h exp=%h", it, i, rx_q[i], exp_q[i]); end
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) app_write(8'($urandom_range(0, 255)));
    in_req_i = 1'b1;
    tick();
    in_ready_i = 1'b1;
    tick();
    tick();
    in_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      out_data_i  = 8'($urandom_range(0, 255));
      out_valid_i = 1'b1;
      out_ready_i = 1'b1;
      tick();
    end
    rst_i = 1'b1;
    tick();
    test_reset();
    idle_inputs();
    rst_i = 1'b0;
    in_model.delete();
    out_model.delete();
    zlp_model = 1'b0;
    tick();
    tick();
    checks++; if (in_nak_o !== 1'b1) begin errors++; $display("FAIL rmid_in_nak got=%b exp=1", in_nak_o); end
    checks++; if (app_out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", app_out_valid_o); end
  endtask

  initial begin
    idle_inputs();
    zlp_model = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    test_reset();
    test_in_split();
    test_zlp();
    test_retry();
    test_out_nak();
    test_out_err();
    test_random();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bulk_endp_fifo.md
Name: bulk_endp_fifo

Overview:
Next-generation single-clock USB 2.0 full-speed IN/OUT bulk endpoint pair. FIFO depth is decoupled from max packet size, so several packets can be buffered per direction.
- OUT: NAK is decided per packet at its first byte, based on free space.
- IN: empty FIFO gives an explicit NAK; a terminating zero-length packet (ZLP) is optional; unacknowledged packets are retried.
- Sits between the SIE and application logic.

Parameters:
IN_MAXPACKETSIZE, 8, max bytes per IN data packet (1..64)
OUT_MAXPACKETSIZE, 8, max bytes per OUT data packet (1..64)
IN_DEPTH, 16, IN FIFO bytes; power of two, >= IN_MAXPACKETSIZE
OUT_DEPTH, 16, OUT FIFO bytes; power of two, >= OUT_MAXPACKETSIZE
ZLP_EN, 1, 1: send a ZLP after a full-size IN packet that empties the FIFO

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
app_in_data_i  in  8  byte to IN FIFO
app_in_valid_i  in  1  app_in_data_i valid
app_in_ready_o  out  1  IN FIFO not full; byte taken when valid&ready
app_out_data_o  out  8  OUT FIFO head byte
app_out_valid_o  out  1  committed OUT byte available
app_out_ready_i  in  1  head consumed when valid&ready
in_level_o  out  IW+1  committed bytes in IN FIFO (IW=clog2(IN_DEPTH))
out_level_o  out  OW+1  committed bytes in OUT FIFO (OW=clog2(OUT_DEPTH))
in_req_i  in  1  high during an SIE IN transaction
in_ready_i  in  1  one-cycle pulse: in_data_o consumed
in_data_o  out  8  IN byte to SIE
in_valid_o  out  1  IN byte available within current packet
in_nak_o  out  1  IN token must be NAKed
out_data_i  in  8  OUT byte from SIE
out_valid_i  in  1  OUT byte valid
out_err_i  in  1  with out_ready_i: abort current OUT packet
out_ready_i  in  1  one-cycle strobe (consume / end / ACK)
out_nak_o  out  1  current OUT packet must be NAKed

Behaviour:
Reset values:
- All pointers 0; levels 0.
- app_out_valid_o=0, app_in_ready_o=1, in_valid_o=0, out_nak_o=0, in_nak_o=1 (FIFO empty, no ZLP pending), in_data_o=0, zlp_pending=0.
- Reset mid-packet discards all FIFO content and uncommitted state.

Pointers:
- Each FIFO has pointers of width W+1 (extra wrap bit).
- full = MSBs differ and LSBs equal; empty = pointers equal.
- Wrap is natural modulo 2^(W+1).

App side (one byte per clock, no throttle):
- app_in_ready_o = !full(IN). The byte is written at the write pointer on the same edge.
- app_out_valid_o = (committed OUT write pointer != read pointer). app_out_data_o is the head byte, combinational from storage.

OUT FSM (advances only on out_ready_i): OUT_IDLE, OUT_DATA, OUT_NAK.
- IDLE + out_valid_i:
  - if free space (OUT_DEPTH - out_level) < OUT_MAXPACKETSIZE, go to OUT_NAK and set out_nak_o=1;
  - otherwise write the byte at the speculative pointer and go to OUT_DATA.
- DATA + out_valid_i: write the byte and advance the speculative pointer. Bytes beyond OUT_MAXPACKETSIZE are dropped and force NAK.
- out_valid_i=0, out_err_i=0 (end of packet):
  - in DATA, commit the speculative pointer to the committed pointer;
  - in NAK, discard;
  - then go to IDLE and clear out_nak_o.
- out_err_i: speculative pointer reverts to committed pointer, out_nak_o=0, go to IDLE.
- App reads during an OUT packet are unaffected. Committed data becomes visible the cycle after commit.

IN FSM: IN_IDLE, IN_SEND, IN_WAIT_ACK.
- Rising edge of in_req_i: the speculative read pointer loads from the committed read pointer; go to SEND.
- in_nak_o = (committed level == 0) && !zlp_pending, registered, updated every cycle while in IDLE.
- SEND:
  - in_valid_o = (bytes sent < IN_MAXPACKETSIZE) && (spec pointer != write pointer);
  - each in_ready_i advances the spec pointer and the sent count;
  - falling edge of in_req_i goes to WAIT_ACK.
- WAIT_ACK:
  - out_ready_i with out_valid_i=0 and out_err_i=0 is the ACK: commit the spec pointer to the read pointer, set zlp_pending = ZLP_EN && sent==IN_MAXPACKETSIZE && FIFO now empty, go to IDLE;
  - a new in_req_i rise first (no ACK) means retry: reload from the committed pointer, go to SEND, same bytes are resent.
- A ZLP transaction (zlp_pending=1, level 0) sends 0 bytes; its ACK clears zlp_pending.
- App writes during an IN packet land after the write pointer. They may extend the current packet up to IN_MAXPACKETSIZE.

Simultaneous events:
- App read and OUT commit in the same cycle: level = old + committed - 1.
- App write and IN ACK in the same cycle: both apply.

Decomposition:
- Package bulk_endp_pkg: OUT/IN state encodings, ceil_log2 function.
- Sub-module sync_fifo_spec: one instance per direction. It holds storage, write/read pointers, speculative pointer with commit/revert, level and full/empty, parametrised by DEPTH. The top holds both FSMs.

Test Plan:
- App writes 10 bytes, IN_MPS=8, ACK each packet -> packet 1 = 8 bytes, packet 2 = 2 bytes, then in_nak_o=1 and in_level_o=0.
- App writes exactly 8 bytes, ZLP_EN=1 -> 8-byte packet, ACK, next IN sends 0 bytes with in_nak_o=0; after that ACK in_nak_o=1.
- IN packet of bytes 0x11..0x18 with no ACK, then new in_req_i -> same 0x11..0x18 resent; in_level_o stays 8 until ACK.
- OUT_DEPTH=16, 12 committed bytes unread, new OUT packet -> out_nak_o=1 from first byte, nothing stored, out_level_o=12.
- OUT packet 0xA0..0xA4 then out_err_i -> out_level_o=0, app_out_valid_o=0; next good 3-byte packet commits with out_level_o=3.
- rst_i asserted mid IN packet and mid OUT packet -> all outputs at reset values next cycle; FIFOs empty.
